// File: rtl/operand_mem_pkg.sv
// Shared constants for the operand register file: FSM encoding, LFSR
// polynomial/seed and init-mode codes, plus the LFSR next-state helper.
package operand_mem_pkg;

    // Sequencer state encoding
    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    // 16-bit Galois LFSR, right-shifting, taps applied when bit 0 falls out
    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] INIT_SEED_DEFAULT = 16'hACE1;

    // Fill pattern selection
    localparam int INIT_ZERO = 0;
    localparam int INIT_LFSR = 1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return (state >> 1) ^ (state[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/operand_regfile_if.sv
// Controller-side bus of the operand register file: init handshake,
// one write port and NUM_RD flattened read ports.
interface operand_regfile_if #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                      init_req;
    logic                      init_busy;
    logic                      wr_en;
    logic [AW-1:0]             wr_addr;
    logic [WIDTH-1:0]          wr_data;
    logic [NUM_RD-1:0]         rd_en;
    logic [NUM_RD*AW-1:0]      rd_addr;
    logic [NUM_RD*WIDTH-1:0]   rd_data;
    logic [NUM_RD-1:0]         rd_valid;

    // Controller drives requests, sees data and status
    modport master (
        output init_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  init_busy, rd_data, rd_valid
    );

    // Register file consumes requests, returns data and status
    modport slave (
        input  init_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output init_busy, rd_data, rd_valid
    );
endinterface

// File: rtl/operand_init_lfsr.sv
// 16-bit Galois LFSR used by the fill sequencer. Reset and load both
// return it to SEED; step advances one position.
module operand_init_lfsr
    import operand_mem_pkg::*;
#(
    parameter logic [15:0] SEED = INIT_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_step,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    // Reseed on reset or load; otherwise advance when stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= SEED;
        end else if (i_step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/operand_regfile.sv
// Parametrised operand register file: NUM_RD registered read ports with
// write-first bypass, one write port, and a fill sequencer that sweeps
// the array with zeros or an LFSR pattern after reset or on init_req.
module operand_regfile
    import operand_mem_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          DEPTH     = 16,
    parameter int          NUM_RD    = 2,
    parameter int          INIT_MODE = INIT_ZERO,
    parameter logic [15:0] INIT_SEED = INIT_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    operand_regfile_if.slave  bus
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
    // One extra bit so DEPTH itself is representable for range checks
    localparam logic [AW:0]     DEPTH_W   = (AW + 1)'(DEPTH);

    logic [0:0]        r_state;
    logic [AW-1:0]     r_sweep_addr;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_busy;
    logic              w_ready;
    logic              w_restart;
    logic              w_accept;
    logic              w_sweep_last;
    logic              w_wr_in_range;
    logic              w_wr_accept;
    logic [15:0]       w_lfsr_state;
    logic [WIDTH-1:0]  w_lfsr_fill;
    logic [WIDTH-1:0]  w_fill_data;
    logic              w_mem_we;
    logic [AW-1:0]     w_mem_addr;
    logic [WIDTH-1:0]  w_mem_wdata;

    assign w_busy        = (r_state == S_INIT);
    assign w_ready       = (r_state == S_READY);
    // A restart request swallows every other request in its cycle
    assign w_restart     = w_ready && bus.init_req;
    assign w_accept      = w_ready && !bus.init_req;
    assign w_sweep_last  = (r_sweep_addr == LAST_ADDR);
    assign w_wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);
    assign w_wr_accept   = w_accept && bus.wr_en && w_wr_in_range;

    assign bus.init_busy = w_busy;

    // Sequencer: sweep every entry once, then serve requests until init_req
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_INIT;
            r_sweep_addr <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (w_sweep_last) begin
                        r_state      <= S_READY;
                        r_sweep_addr <= '0;
                    end else begin
                        r_sweep_addr <= r_sweep_addr + 1'b1;
                    end
                end
                default: begin
                    if (bus.init_req) begin
                        r_state      <= S_INIT;
                        r_sweep_addr <= '0;
                    end
                end
            endcase
        end
    end

    operand_init_lfsr #(
        .SEED    (INIT_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_restart),
        .i_step  (w_busy),
        .o_state (w_lfsr_state)
    );

    // Fit the 16-bit LFSR state to the data width
    generate
        if (WIDTH > 16) begin : g_fill_wide
            assign w_lfsr_fill = {{(WIDTH - 16){1'b0}}, w_lfsr_state};
        end else begin : g_fill_narrow
            assign w_lfsr_fill = w_lfsr_state[WIDTH-1:0];
        end
    endgenerate

    assign w_fill_data = (INIT_MODE == INIT_LFSR) ? w_lfsr_fill : '0;

    // Single physical write port shared by the sweep and the user
    always_comb begin
        w_mem_we    = w_wr_accept;
        w_mem_addr  = bus.wr_addr;
        w_mem_wdata = bus.wr_data;
        if (w_busy) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_sweep_addr;
            w_mem_wdata = w_fill_data;
        end
    end

    // Storage array: no reset, contents defined by the sweep
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Per-port registered read with range check and write-first bypass
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0]    w_addr;
            logic             w_in_range;
            logic             w_hit;
            logic             w_take;
            logic [WIDTH-1:0] r_data;
            logic             r_valid;

            assign w_addr     = bus.rd_addr[gi*AW +: AW];
            assign w_in_range = ({1'b0, w_addr} < DEPTH_W);
            assign w_hit      = w_wr_accept && (bus.wr_addr == w_addr);
            assign w_take     = w_accept && bus.rd_en[gi];

            // Load data on an accepted request, hold it otherwise
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_take;
                    if (w_take) begin
                        if (!w_in_range) begin
                            r_data <= '0;
                        end else if (w_hit) begin
                            r_data <= bus.wr_data;
                        end else begin
                            r_data <= r_mem[w_addr];
                        end
                    end
                end
            end

            assign bus.rd_data[gi*WIDTH +: WIDTH] = r_data;
            assign bus.rd_valid[gi]               = r_valid;
        end
    endgenerate

endmodule

// File: tb/tb_operand_regfile.sv
// Directed bench for operand_regfile: three instances (zero fill depth 16,
// LFSR fill depth 16, zero fill depth 12) driven from one sequence.
module tb_operand_regfile;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    operand_regfile_if #(.WIDTH(16), .DEPTH(16), .NUM_RD(2)) if0 ();
    operand_regfile_if #(.WIDTH(16), .DEPTH(16), .NUM_RD(2)) if1 ();
    operand_regfile_if #(.WIDTH(16), .DEPTH(12), .NUM_RD(2)) if2 ();

    operand_regfile #(.WIDTH(16), .DEPTH(16), .NUM_RD(2), .INIT_MODE(0), .INIT_SEED(16'hACE1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    operand_regfile #(.WIDTH(16), .DEPTH(16), .NUM_RD(2), .INIT_MODE(1), .INIT_SEED(16'hACE1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    operand_regfile #(.WIDTH(16), .DEPTH(12), .NUM_RD(2), .INIT_MODE(0), .INIT_SEED(16'hACE1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-16s ok  value %h", tag, obs);
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if0.init_req = 0; if0.wr_en = 0; if0.wr_addr = 0; if0.wr_data = 0; if0.rd_en = 0; if0.rd_addr = 0;
        if1.init_req = 0; if1.wr_en = 0; if1.wr_addr = 0; if1.wr_data = 0; if1.rd_en = 0; if1.rd_addr = 0;
        if2.init_req = 0; if2.wr_en = 0; if2.wr_addr = 0; if2.wr_data = 0; if2.rd_en = 0; if2.rd_addr = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        chk("rst_busy0",   32'(if0.init_busy), 32'd1);
        chk("rst_valid0",  32'(if0.rd_valid),  32'd0);
        chk("rst_data0",   32'(if0.rd_data),   32'd0);
        chk("rst_data1",   32'(if1.rd_data),   32'd0);
        chk("rst_busy2",   32'(if2.init_busy), 32'd1);

        // Sweep, with requests on dut0 that must all be ignored
        if0.init_req = 1; if0.wr_en = 1; if0.wr_addr = 4'd2; if0.wr_data = 16'hFFFF;
        if0.rd_en = 2'b11; if0.rd_addr = {4'd2, 4'd5};
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("sweep_busy16", 32'(if0.init_busy), 32'(k < 16));
            chk("sweep_busy12", 32'(if2.init_busy), 32'(k < 12));
            chk("sweep_valid0", 32'(if0.rd_valid),  32'd0);
            if (k == 5) idle_all();
        end

        // R1: first reads after the sweep; out-of-range write/read on dut2
        if0.rd_en = 2'b11; if0.rd_addr = {4'd2, 4'd5};
        if1.rd_en = 2'b11; if1.rd_addr = {4'd1, 4'd0};
        if2.wr_en = 1; if2.wr_addr = 4'd13; if2.wr_data = 16'hAAAA;
        if2.rd_en = 2'b11; if2.rd_addr = {4'd13, 4'd13};
        tick();
        chk("r1_valid0",   32'(if0.rd_valid),        32'd3);
        chk("r1_zero_a5",  32'(if0.rd_data[15:0]),   32'h0000);
        chk("r1_drop_a2",  32'(if0.rd_data[31:16]),  32'h0000);
        chk("r1_lfsr_a0",  32'(if1.rd_data[15:0]),   32'hACE1);
        chk("r1_lfsr_a1",  32'(if1.rd_data[31:16]),  32'hE270);
        chk("r1_valid2",   32'(if2.rd_valid),        32'd3);
        chk("r1_oor_p0",   32'(if2.rd_data[15:0]),   32'h0000);
        chk("r1_oor_p1",   32'(if2.rd_data[31:16]),  32'h0000);

        // R2: write-first bypass on both full-depth instances
        idle_all();
        if0.wr_en = 1; if0.wr_addr = 4'd3; if0.wr_data = 16'h1234;
        if0.rd_en = 2'b11; if0.rd_addr = {4'd3, 4'd5};
        if1.wr_en = 1; if1.wr_addr = 4'd0; if1.wr_data = 16'hBEEF;
        if1.rd_en = 2'b11; if1.rd_addr = {4'd2, 4'd0};
        if2.rd_en = 2'b11; if2.rd_addr = {4'd11, 4'd13};
        tick();
        chk("r2_byp_p1",   32'(if0.rd_data[31:16]),  32'h1234);
        chk("r2_p0_a5",    32'(if0.rd_data[15:0]),   32'h0000);
        chk("r2_byp_lfsr", 32'(if1.rd_data[15:0]),   32'hBEEF);
        chk("r2_lfsr_a2",  32'(if1.rd_data[31:16]),  32'h7138);
        chk("r2_a11",      32'(if2.rd_data[31:16]),  32'h0000);

        // R3: stored write visible later; hold on idle port; shared address
        idle_all();
        if0.rd_en = 2'b01; if0.rd_addr = {4'd0, 4'd3};
        if1.rd_en = 2'b11; if1.rd_addr = {4'd1, 4'd1};
        if2.wr_en = 1; if2.wr_addr = 4'd11; if2.wr_data = 16'h5A5A;
        if2.rd_en = 2'b01; if2.rd_addr = {4'd0, 4'd11};
        tick();
        chk("r3_valid0",   32'(if0.rd_valid),        32'd1);
        chk("r3_read_a3",  32'(if0.rd_data[15:0]),   32'h1234);
        chk("r3_hold_p1",  32'(if0.rd_data[31:16]),  32'h1234);
        chk("r3_same_p0",  32'(if1.rd_data[15:0]),   32'hE270);
        chk("r3_same_p1",  32'(if1.rd_data[31:16]),  32'hE270);
        chk("r3_byp_d12",  32'(if2.rd_data[15:0]),   32'h5A5A);
        chk("r3_valid2",   32'(if2.rd_valid),        32'd1);

        // R4: init_req from ready drops same-cycle requests
        idle_all();
        if0.init_req = 1; if0.wr_en = 1; if0.wr_addr = 4'd4; if0.wr_data = 16'h7777;
        if0.rd_en = 2'b01; if0.rd_addr = {4'd0, 4'd3};
        if1.init_req = 1; if1.rd_en = 2'b01; if1.rd_addr = {4'd0, 4'd0};
        tick();
        chk("r4_busy0",    32'(if0.init_busy),       32'd1);
        chk("r4_valid0",   32'(if0.rd_valid),        32'd0);
        chk("r4_hold0",    32'(if0.rd_data[15:0]),   32'h1234);
        chk("r4_busy1",    32'(if1.init_busy),       32'd1);
        idle_all();
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("resweep_busy", 32'(if0.init_busy), 32'(k < 16));
        end

        // R5: entries re-zeroed / reseeded pattern restored
        if0.rd_en = 2'b11; if0.rd_addr = {4'd4, 4'd3};
        if1.rd_en = 2'b11; if1.rd_addr = {4'd1, 4'd0};
        tick();
        chk("r5_rezero_a3", 32'(if0.rd_data[15:0]),  32'h0000);
        chk("r5_drop_a4",   32'(if0.rd_data[31:16]), 32'h0000);
        chk("r5_reseed_a0", 32'(if1.rd_data[15:0]),  32'hACE1);
        chk("r5_reseed_a1", 32'(if1.rd_data[31:16]), 32'hE270);

        // R6: load a non-zero value into dut0 port 0
        idle_all();
        if0.wr_en = 1; if0.wr_addr = 4'd9; if0.wr_data = 16'hABCD;
        if0.rd_en = 2'b01; if0.rd_addr = {4'd0, 4'd9};
        tick();
        chk("r6_byp_a9",   32'(if0.rd_data[15:0]),   32'hABCD);

        // R7: restart sweep, then assert reset at sweep edge 7
        idle_all();
        if0.init_req = 1;
        tick();
        idle_all();
        repeat (6) tick();
        chk("r7_busy_mid", 32'(if0.init_busy),       32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r7_rst_data0", 32'(if0.rd_data),        32'd0);
        chk("r7_rst_data1", 32'(if1.rd_data),        32'd0);
        chk("r7_rst_busy0", 32'(if0.init_busy),      32'd1);
        chk("r7_rst_valid", 32'(if1.rd_valid),       32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("rst_resweep", 32'(if0.init_busy), 32'(k < 16));
        end

        // R8: contents after the post-reset sweep
        if0.rd_en = 2'b11; if0.rd_addr = {4'd3, 4'd9};
        if1.rd_en = 2'b01; if1.rd_addr = {4'd0, 4'd0};
        tick();
        chk("r8_zero_a9",  32'(if0.rd_data[15:0]),   32'h0000);
        chk("r8_zero_a3",  32'(if0.rd_data[31:16]),  32'h0000);
        chk("r8_seed_a0",  32'(if1.rd_data[15:0]),   32'hACE1);
        chk("r8_valid1",   32'(if1.rd_valid),        32'd1);

        idle_all();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_regfile.md
# operand_regfile

Parametrised operand storage for the datapath, succeeding the fixed 16x16 single-read operand ROM. It provides NUM_RD independent registered read ports, one write port with write-first bypass, and a hardware init sequencer. The sequencer fills the array with zeros or a pseudo-random LFSR pattern after reset or on request. It sits between the controller (address/request side) and the ALU operand inputs.

## Interface
- WIDTH, 16: data word width, 1..32
- DEPTH, 16: number of entries, 2..256; need not be a power of two
- NUM_RD, 2: read port count, 1..4
- INIT_MODE, 0: 0 = fill with zeros, 1 = fill with LFSR sequence
- INIT_SEED, 16'hACE1: LFSR seed (must be nonzero)
- AW (localparam): $clog2(DEPTH)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- init_req  in  1  pulse; restarts fill sweep when idle
- init_busy  out  1  high while sweep runs; ports are not ready
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*AW  flattened; port p at [p*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  flattened registered read data
- rd_valid  out  NUM_RD  per-port; high one cycle after an accepted request

## Operation
- FSM states: S_INIT (sweep) and S_READY.
- Reset enters S_INIT with sweep address 0 and LFSR = INIT_SEED.
- S_INIT: each cycle writes entry sweep_addr, then increments it.
  - INIT_MODE 0 writes 0.
  - INIT_MODE 1 writes the LFSR state truncated or zero-extended to WIDTH, then advances the LFSR.
  - LFSR: 16-bit Galois, right shift, XOR 16'hB400 when the shifted-out bit is 1.
  - After writing DEPTH-1, go to S_READY.
- S_READY with init_req=1: return to S_INIT with address 0 and reseeded LFSR. The wr_en and rd_en in that cycle are dropped.
- init_req during S_INIT is ignored (the sweep does not restart).
- While in S_INIT: wr_en is ignored, rd_en is not accepted, and rd_valid stays 0.
- Write: in S_READY with wr_en=1 and wr_addr<DEPTH, the entry is updated at the clock edge. If wr_addr>=DEPTH, the write is dropped.
- Read (port p): in S_READY with rd_en[p]=1, rd_data[p] is loaded at the edge.
  - If rd_addr>=DEPTH, loads 0.
  - If the address matches a same-cycle accepted write, loads wr_data (write-first bypass).
  - Otherwise loads the stored entry.
- Multiple ports may read the same address in one cycle.
- When rd_en[p]=0, rd_data[p] holds its last value and rd_valid[p]=0.

## Timing
- Reset values: init_busy=1, rd_valid=0, rd_data=0. Array contents are undefined until the sweep completes.
- Sweep length: first rising edge after rst_n deasserts writes entry 0; init_busy falls after edge DEPTH.
  - With DEPTH=16, the first accepted read is at edge 17.
- Read latency: 1 cycle. Request at edge n produces data and valid after edge n+1. Full throughput with no bubbles.
- Writes are visible to the same-cycle read (bypass) and to all later reads.
- rst_n asserted mid-sweep or mid-read: all outputs return to reset values immediately. The sweep restarts from 0 on release.
- init_req issued from S_READY: init_busy rises at the next edge. Outputs issued before that edge complete normally.

## Structure
- Package operand_mem_pkg holds:
  - the state encoding (S_INIT, S_READY)
  - LFSR_POLY = 16'hB400
  - default INIT_SEED
  - INIT_MODE codes INIT_ZERO = 0 and INIT_LFSR = 1
- Sub-module operand_init_lfsr: 16-bit Galois LFSR with load (seed) and step inputs, instantiated once.
- The array is a plain reg array with no reset. Only the control and output registers use the asynchronous reset.

## Test plan
- Reset then sweep, INIT_MODE=0, DEPTH=16: init_busy high for exactly 16 edges. Then reading addr 5 on port 0 returns 16'h0000 with rd_valid one cycle later.
- INIT_MODE=1, seed 16'hACE1: reading addr 0 and 1 on ports 0/1 in the same cycle returns 16'hACE1 and 16'hE270.
- Bypass: write 16'h1234 to addr 3 while port 1 reads addr 3 → 16'h1234. The next cycle, port 0 reads addr 3 → 16'h1234.
- Requests during sweep: rd_en=2'b11 and wr_en=1 during S_INIT → rd_valid stays 0. After the sweep, the written address still reads 0.
- Out of range, DEPTH=12: write addr 13 is dropped. Reading addr 13 returns 0 with rd_valid=1. Reading addr 11 is unaffected.
- Reset mid-sweep at edge 7: outputs cleared. After release, init_busy lasts a full DEPTH edges again. init_req in S_READY re-zeroes a previously written entry.
